// File: rtl/ecc_pkg.sv
// Shared SECDED width helpers, encoded-word layout and injection FSM states.
// Used by the streaming encoder and the matching decoder.
package ecc_pkg;

  // Smallest p with 2^p >= data_width + p + 1; descending scan keeps the minimum.
  function automatic int get_parity_width(input int data_width);
    int p;
    p = 0;
    for (int i = 30; i >= 1; i--) begin
      if ((2 ** i) >= data_width + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic int get_cw_width(input int data_width);
    return data_width + get_parity_width(data_width);
  endfunction

  localparam int DefaultDataWidth = 64;

  typedef struct packed {
    logic                                        parity;
    logic [get_cw_width(DefaultDataWidth)-1:0]   code_word;
  } ecc_enc_t;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

endpackage

// File: rtl/ecc_encode_core.sv
// Combinational SECDED Hamming encoder: data -> {overall parity, code word}.
// Parity bit 2^i covers every position whose index has bit i set.
module ecc_encode_core
  import ecc_pkg::*;
#(
  parameter  int DataWidth   = 64,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CwWidth     = DataWidth + ParityWidth,
  localparam int EncWidth    = CwWidth + 1
) (
  input  logic [DataWidth-1:0] data_i,
  output logic [EncWidth-1:0]  enc_o
);

  typedef struct packed {
    logic               parity;
    logic [CwWidth-1:0] code_word;
  } enc_t;

  logic [CwWidth-1:0] w_placed;
  logic [CwWidth-1:0] w_cw;
  logic               w_par;
  int                 k;
  enc_t               w_enc;

  always_comb begin
    w_placed = '0;
    k        = 0;
    for (int n = 1; n <= CwWidth; n++) begin
      if ((n & (n - 1)) != 0) begin
        w_placed[n-1] = data_i[k];
        k++;
      end
    end
  end

  always_comb begin
    w_cw  = w_placed;
    w_par = 1'b0;
    for (int i = 0; i < ParityWidth; i++) begin
      w_par = 1'b0;
      for (int n = 1; n <= CwWidth; n++) begin
        if (((n >> i) & 1) == 1) w_par = w_par ^ w_placed[n-1];
      end
      w_cw[(1 << i) - 1] = w_par;
    end
  end

  always_comb begin
    w_enc.code_word = w_cw;
    w_enc.parity    = ^w_cw;
  end

  assign enc_o = w_enc;

endmodule

// File: rtl/ecc_encode_stream.sv
// Registered SECDED encoder stage with valid/ready handshake and full throughput.
// Optional one-shot error injection is built only when ECC_ERR_INJECT_EN is defined.
module ecc_encode_stream
  import ecc_pkg::*;
#(
  parameter  int DataWidth   = 64,
  localparam int ParityWidth = get_parity_width(DataWidth),
  localparam int CwWidth     = DataWidth + ParityWidth,
  localparam int EncWidth    = CwWidth + 1,
  localparam int PosWidth    = $clog2(EncWidth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [EncWidth-1:0] data_o,
  input  logic                inject_arm_i,
  input  logic                inject_double_i,
  input  logic [PosWidth-1:0] inject_pos_i,
  output logic                inject_armed_o,
  output logic                injected_o
);

  logic                r_valid;
  logic [EncWidth-1:0] r_data;
  logic                r_injected;
  logic [EncWidth-1:0] w_enc;
  logic [EncWidth-1:0] w_flip;
  logic                w_inj;
  logic                w_in_hs;
  logic                w_out_hs;

  ecc_encode_core #(.DataWidth(DataWidth)) u_core (
    .data_i (data_i),
    .enc_o  (w_enc)
  );

  assign ready_o  = !r_valid || ready_i;
  assign w_in_hs  = valid_i && ready_o;
  assign w_out_hs = r_valid && ready_i;

`ifdef ECC_ERR_INJECT_EN
  localparam logic [PosWidth:0] EncWidthL = EncWidth;
  localparam logic [PosWidth-1:0] LastPos = PosWidth'(EncWidth - 1);

  inj_state_e          r_state, w_state_d;
  logic                r_double;
  logic [PosWidth-1:0] r_pos;
  logic                w_consume;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= INJ_IDLE;
      r_double <= 1'b0;
      r_pos    <= '0;
    end else begin
      r_state <= w_state_d;
      if (inject_arm_i) begin
        r_double <= inject_double_i;
        r_pos    <= inject_pos_i;
      end
    end
  end

  // A fresh arm in the consuming cycle re-arms; the consumed beat still uses the old latch.
  always_comb begin
    w_state_d = r_state;
    w_consume = 1'b0;
    w_flip    = '0;
    w_inj     = 1'b0;
    if (r_state == INJ_ARMED && w_in_hs) begin
      w_consume = 1'b1;
      w_state_d = INJ_IDLE;
    end
    if (inject_arm_i) w_state_d = INJ_ARMED;
    if (w_consume && ({1'b0, r_pos} < EncWidthL)) begin
      w_inj         = 1'b1;
      w_flip[r_pos] = 1'b1;
      if (r_double) begin
        if (r_pos == LastPos) w_flip[0] = 1'b1;
        else                  w_flip[r_pos + 1'b1] = 1'b1;
      end
    end
  end

  assign inject_armed_o = (r_state == INJ_ARMED);
`else
  logic w_unused_inject;
  assign w_unused_inject = ^{inject_arm_i, inject_double_i, inject_pos_i};
  assign w_flip          = '0;
  assign w_inj           = 1'b0;
  assign inject_armed_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_injected <= 1'b0;
    end else if (w_in_hs) begin
      r_valid    <= 1'b1;
      r_data     <= w_enc ^ w_flip;
      r_injected <= w_inj;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o    = r_valid;
  assign data_o     = r_data;
  assign injected_o = r_injected;

endmodule

// File: doc/ecc_encode_stream.md
# ecc_encode_stream

Streaming SECDED Hamming encoder with a valid/ready handshake on both sides. It accepts unencoded data words and emits registered encoded words (code word plus overall parity MSB) one cycle later. It runs at full throughput and holds its output stable under backpressure. It sits on the write path in front of ECC-protected memories and links, and its output format is exactly what the SECDED decoder consumes.

## Interface
- `DataWidth`, default 64: unencoded word width.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `valid_i`, input, 1: input beat valid.
- `ready_o`, output, 1: input beat accepted when `valid_i && ready_o`.
- `data_i`, input, `DataWidth`: unencoded data.
- `valid_o`, output, 1: encoded beat valid.
- `ready_i`, input, 1: downstream accepts when `valid_o && ready_i`.
- `data_o`, output, `EncWidth`: `{parity, code_word}`.
- `inject_arm_i`, input, 1: pulse to arm a one-shot error injection.
- `inject_double_i`, input, 1: sampled with the arm pulse. 0 selects a single-bit flip, 1 selects a double-bit flip.
- `inject_pos_i`, input, `$clog2(EncWidth)`: bit position, sampled with the arm pulse.
- `inject_armed_o`, output, 1: injection is pending.
- `injected_o`, output, 1: the current output beat carries an injected error. Qualified by `valid_o`.

Width derivation:
- `ParityWidth` is the smallest p with 2^p ≥ `DataWidth` + p + 1.
- `CwWidth` = `DataWidth` + `ParityWidth`.
- `EncWidth` = `CwWidth` + 1.
- For `DataWidth` = 64 these are 7, 71 and 72.

## Operation
Code word layout:
- Positions are 1..`CwWidth`; position n maps to bit n-1.
- Power-of-two positions hold parity bits.
- Data bits fill the remaining positions in ascending order, LSB first.
- Parity bit 2^i is the XOR of all data bits at positions j where j & 2^i ≠ 0.
- The MSB is the XOR of all code word bits, so the XOR over all of `data_o` is 0.

Pipeline:
- Single output register holding `valid_q`, `data_q` and `injected_q`.
- `ready_o` = `!valid_q || ready_i`.
- On an input handshake, the encoded word is loaded into `data_q` and `valid_q` is set.
- On an output handshake with no input handshake, `valid_q` is cleared.

Injection FSM, states IDLE and ARMED:
- IDLE → ARMED on `inject_arm_i`. The type and position are latched at the same time.
- ARMED → IDLE on the first input handshake in a later cycle. That beat is corrupted and `injected_q` is set for it.
- An arm pulse while ARMED overwrites the latched type and position.
- An arm pulse in the same cycle as a consuming handshake leaves the FSM ARMED with the new values. The consumed beat uses the old values.
- Single flip: bit `pos`.
- Double flip: bits `pos` and `(pos+1) mod EncWidth`, so `pos` = `EncWidth`-1 also flips bit 0.
- If `pos` ≥ `EncWidth`, the arm is consumed, the beat passes unmodified and `injected_q` stays 0.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `injected_o` = 0, `inject_armed_o` = 0, FSM in IDLE.
- `ready_o` is combinational from `valid_q` and `ready_i`. While `valid_q` is 0 it is high, including immediately after reset.
- Latency is 1 cycle from the input handshake to `valid_o`.
- Throughput is 1 beat per cycle while `ready_i` is held high.
- Backpressure: while `valid_o && !ready_i`, `data_o` and `injected_o` hold and `ready_o` is 0.
- Reset asserted mid-operation: the pending beat and the arm are discarded and all outputs return to their reset values asynchronously.
- `inject_armed_o` goes high the cycle after the arm pulse. It goes low the cycle after the consuming handshake.

## Configuration
Macro `ECC_ERR_INJECT_EN`:
- Defined: injection behaves as described above.
- Undefined:
  - The inject ports remain present but are ignored.
  - The FSM and latches are not built.
  - `inject_armed_o` and `injected_o` are tied to 0.
  - `data_o` is always the clean encoding.

## Structure
- `ecc_pkg` holds `get_parity_width`, `get_cw_width` and the encoded-word struct typedef (`parity` MSB, `code_word`), shared with the decoder.
- One combinational sub-module, `ecc_encode_core`, maps `data_i` to the encoded word.
- The pipeline register and injection FSM live in `ecc_encode_stream`.

## Test plan
All scenarios use `DataWidth` = 8, giving `EncWidth` = 13.
- Reset, then `data_i` = 0x00 with `valid_i` = 1 → one cycle later `valid_o` = 1 and `data_o` = 0x0000.
- `data_i` = 0x01 → `data_o` = 0x1007. `data_i` = 0xFF → `data_o` = 0x0F77. Randomized words must round-trip through the decoder with all error flags 0.
- `ready_i` = 0 for 3 cycles with `data_i` = 0x01 queued behind 0xFF:
  - `data_o` holds 0x0F77 and `ready_o` = 0.
  - After `ready_i` rises, 0x1007 follows on the next cycle with no beat lost or duplicated.
- Arm with single flip at `pos` = 0, then send 0x01:
  - `data_o` = 0x1006 and `injected_o` = 1.
  - The next beat, 0x01, is clean (0x1007).
  - The decoder reports single_error with syndrome 1.
- Arm with double flip at `pos` = 12, then send 0x00 → `data_o` = 0x1001 and the decoder reports double_error.
- Assert reset while ARMED and `valid_o` = 1 → all outputs are 0. A following beat of 0x01 encodes clean.
